// File: rtl/msp430_clock_gate_ctrl.sv
// msp430_clock_gate_ctrl: per-channel enable sequencer for msp430_clock_gate cells.
// Each channel wakes with a settle delay before ack and lingers after release
// before gating off. Optional feature macro: CLKGATE_DBG_FORCE_EN (adds dbg_force,
// which forces every cg_enable high after the registers).

// One channel: OFF -> WAKE -> ON -> LINGER -> OFF, enable/ack registered.
module msp430_clock_gate_ch #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic puc_rst_n,
    input  logic req,
    input  logic busy,
    output logic enable,
    output logic ack
);
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ON     = 2'd2,
        ST_LINGER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, ack_q;

    // State, counter and the decoded outputs are all flops so enable is glitch-free.
    always_ff @(posedge clk) begin
        if (!puc_rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d != ST_OFF);
            ack_q   <= (state_d == ST_ON);
        end
    end

    // Next-state: counters load on entry to WAKE/LINGER and never go below one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (req) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_WAKE;
                        cnt_d   = WAKE_LD;
                    end
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion; ON re-evaluates req afterwards.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ON: begin
                if (!req && !busy) begin
                    if (IDLE_CYCLES == 0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_LINGER;
                        cnt_d   = IDLE_LD;
                    end
                end
            end
            ST_LINGER: begin
                // Renewed demand beats expiry on the same edge.
                if (req || busy) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign enable = en_q;
    assign ack    = ack_q;
endmodule

// Top: array of independent channels plus the optional debug force.
module msp430_clock_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              puc_rst_n,
`ifdef CLKGATE_DBG_FORCE_EN
    input  logic              dbg_force,
`endif
    input  logic [NUM_CH-1:0] cg_req,
    input  logic [NUM_CH-1:0] cg_busy,
    output logic [NUM_CH-1:0] cg_enable,
    output logic [NUM_CH-1:0] cg_ack,
    output logic              any_on
);
    logic [NUM_CH-1:0] en_reg;

    msp430_clock_gate_ch #(
        .WAKE_CYCLES (WAKE_CYCLES),
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ch [NUM_CH-1:0] (
        .clk       (clk),
        .puc_rst_n (puc_rst_n),
        .req       (cg_req),
        .busy      (cg_busy),
        .enable    (en_reg),
        .ack       (cg_ack)
    );

`ifdef CLKGATE_DBG_FORCE_EN
    // Force sits after the registers so release takes effect the same cycle.
    assign cg_enable = en_reg | {NUM_CH{dbg_force}};
`else
    assign cg_enable = en_reg;
`endif

    assign any_on = |cg_enable;
endmodule

// File: tb/tb_msp430_clock_gate_ctrl.sv
// Bench for msp430_clock_gate_ctrl: default-parameter instance (a) and
// zero-delay instance (b), directed literal checks plus random traffic
// compared every cycle against a cycle-count model.
module tb_msp430_clock_gate_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_a = '0, busy_a = '0, en_a, ack_a;
    logic [N-1:0] req_b = '0, busy_b = '0, en_b, ack_b;
    logic         on_a, on_b;
    logic         dbg = 1'b0;
    bit           chk_on = 1'b0;
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    msp430_clock_gate_ctrl #(.NUM_CH(N)) dut_a (
        .clk(clk), .puc_rst_n(rst_n),
`ifdef CLKGATE_DBG_FORCE_EN
        .dbg_force(dbg),
`endif
        .cg_req(req_a), .cg_busy(busy_a), .cg_enable(en_a), .cg_ack(ack_a), .any_on(on_a)
    );

    msp430_clock_gate_ctrl #(.NUM_CH(N), .WAKE_CYCLES(0), .IDLE_CYCLES(0)) dut_b (
        .clk(clk), .puc_rst_n(rst_n),
`ifdef CLKGATE_DBG_FORCE_EN
        .dbg_force(dbg),
`endif
        .cg_req(req_b), .cg_busy(busy_b), .cg_enable(en_b), .cg_ack(ack_b), .any_on(on_b)
    );

    // Model: powered/acked flags plus "edges remaining" until ack or until off.
    bit powered [2][N];
    bit acked   [2][N];
    int wake_rem[2][N];
    int idle_rem[2][N];

    function automatic int wake_of(input int k); return (k == 0) ? 2 : 0; endfunction
    function automatic int idle_of(input int k); return (k == 0) ? 8 : 0; endfunction

    task automatic model_step(input int k, input logic [N-1:0] r, input logic [N-1:0] b);
        for (int c = 0; c < N; c++) begin
            if (!rst_n) begin
                powered[k][c] = 0; acked[k][c] = 0; wake_rem[k][c] = 0; idle_rem[k][c] = 0;
            end else if (!powered[k][c]) begin
                if (r[c]) begin
                    powered[k][c] = 1;
                    if (wake_of(k) == 0) acked[k][c] = 1;
                    else wake_rem[k][c] = wake_of(k);
                end
            end else if (wake_rem[k][c] > 0) begin
                wake_rem[k][c]--;
                if (wake_rem[k][c] == 0) acked[k][c] = 1;
            end else if (acked[k][c]) begin
                if (!r[c] && !b[c]) begin
                    acked[k][c] = 0;
                    if (idle_of(k) == 0) powered[k][c] = 0;
                    else idle_rem[k][c] = idle_of(k);
                end
            end else begin
                if (r[c] || b[c]) begin
                    acked[k][c] = 1; idle_rem[k][c] = 0;
                end else begin
                    idle_rem[k][c]--;
                    if (idle_rem[k][c] == 0) powered[k][c] = 0;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_en(input int k);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = powered[k][c];
`ifdef CLKGATE_DBG_FORCE_EN
        if (dbg) v = '1;
`endif
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ack(input int k);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = acked[k][c];
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge as the DUT; inputs only change at negedge.
    always @(posedge clk) begin
        model_step(0, req_a, busy_a);
        model_step(1, req_b, busy_b);
    end

    // Every-cycle comparison, away from both edges.
    always @(posedge clk) begin
        #3;
        if (chk_on) begin
            chk("en_a", en_a, exp_en(0));
            chk("ack_a", ack_a, exp_ack(0));
            chk("any_on_a", {{(N-1){1'b0}}, on_a}, {{(N-1){1'b0}}, |exp_en(0)});
            chk("en_b", en_b, exp_en(1));
            chk("ack_b", ack_b, exp_ack(1));
            chk("any_on_b", {{(N-1){1'b0}}, on_b}, {{(N-1){1'b0}}, |exp_en(1)});
        end
    end

    initial begin
        // Reset held with requests asserted.
        req_a = '1; req_b = '1;
        repeat (3) begin
            @(negedge clk);
            chk_on = 1'b1;
            chk("rst_en", en_a, 4'h0);
            chk("rst_ack", ack_a, 4'h0);
            chk("rst_any_on", {3'b0, on_a}, 4'h0);
            chk("rst_en_b", en_b, 4'h0);
        end
        rst_n = 1'b1; req_a = '0; req_b = '0;

        // Wake latency on channel 0.
        @(negedge clk); req_a = 4'h1;
        @(negedge clk); chk("wake_en", en_a, 4'h1); chk("wake_ack0", ack_a, 4'h0);
        @(negedge clk); chk("wake_ack1", ack_a, 4'h0);
        @(negedge clk); chk("wake_ack2", ack_a, 4'h1); chk("wake_en2", en_a, 4'h1);

        // Linger: enable holds 8 cycles after release.
        req_a = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); chk("linger_en", en_a, 4'h1); chk("linger_ack", ack_a, 4'h0);
        end
        @(negedge clk); chk("linger_off", en_a, 4'h0); chk("linger_any", {3'b0, on_a}, 4'h0);

        // Rescue by busy at cnt==1.
        req_a = 4'h1;
        repeat (3) @(negedge clk);
        chk("rescue_on", ack_a, 4'h1);
        req_a = 4'h0;
        repeat (8) @(negedge clk);
        chk("rescue_last_en", en_a, 4'h1); chk("rescue_last_ack", ack_a, 4'h0);
        busy_a = 4'h1;
        @(negedge clk); chk("rescue_busy_en", en_a, 4'h1); chk("rescue_busy_ack", ack_a, 4'h1);

        // Rescue by req rising on the expiry edge.
        busy_a = 4'h0;
        repeat (8) @(negedge clk);
        req_a = 4'h1;
        @(negedge clk); chk("rescue_req_en", en_a, 4'h1); chk("rescue_req_ack", ack_a, 4'h1);

        // Reset mid-WAKE (ch2) and mid-LINGER (ch3); ch0 also lingering.
        req_a = 4'h8;
        repeat (3) @(negedge clk);
        chk("mid_ack3", ack_a, 4'h8);
        req_a = 4'h4;
        @(negedge clk); chk("mid_en", en_a, 4'hD); chk("mid_ack", ack_a, 4'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", en_a, 4'h0); chk("mid_rst_ack", ack_a, 4'h0);
        chk("mid_rst_any", {3'b0, on_a}, 4'h0);
        rst_n = 1'b1; req_a = 4'h0;

        // Zero wake/idle: immediate on, immediate off.
        @(negedge clk); req_b = 4'h2;
        @(negedge clk); chk("zero_en", en_b, 4'h2); chk("zero_ack", ack_b, 4'h2);
        chk("zero_any", {3'b0, on_b}, 4'h1);
        req_b = 4'h0;
        @(negedge clk); chk("zero_off_en", en_b, 4'h0); chk("zero_off_ack", ack_b, 4'h0);

`ifdef CLKGATE_DBG_FORCE_EN
        // Debug force overrides enables only, combinationally.
        req_a = 4'h1;
        repeat (3) @(negedge clk);
        dbg = 1'b1;
        #1 chk("dbg_en", en_a, 4'hF); chk("dbg_ack", ack_a, 4'h1);
        @(negedge clk); chk("dbg_en_hold", en_a, 4'hF); chk("dbg_ack_hold", ack_a, 4'h1);
        dbg = 1'b0;
        #1 chk("dbg_release", en_a, 4'h1);
        req_a = 4'h0;
`endif

        // Random traffic with sticky requests and occasional reset.
        repeat (2000) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 149) != 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0) req_a[c] = ~req_a[c];
                if ($urandom_range(0, 5) == 0) req_b[c] = ~req_b[c];
                busy_a[c] = ($urandom_range(0, 9) == 0);
                busy_b[c] = ($urandom_range(0, 3) == 0);
            end
`ifdef CLKGATE_DBG_FORCE_EN
            dbg = ($urandom_range(0, 29) == 0);
`endif
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
